uart_tx_framer: RTL

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer_if.sv | 30 +++
 rtl/uart_tx_framer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer_if.sv
// uart_tx_framer_if
// Groups the processor-side handshake and the serial-side outputs of the
// UART transmit framer into one bundle.
//   data_in       : character to send (driven by the processor side)
//   load          : request to send data_in
//   ready         : a load will be accepted
//   busy          : a frame is on the line
//   tx            : serial line, idle high
//   char_complete : one-cycle pulse after each stop bit finishes
// Modports: master = processor/testbench side, slave = framer side.
interface uart_tx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 load;
  logic                 ready;
  logic                 busy;
  logic                 tx;
  logic                 char_complete;

  modport master (
    output data_in, load,
    input  ready, busy, tx, char_complete
  );

  modport slave (
    input  data_in, load,
    output ready, busy, tx, char_complete
  );
endinterface

// File: rtl/uart_tx_framer.sv
// uart_tx_framer
// Serialises characters into UART frames: one start bit (0), DATA_BITS data
// bits LSB first, one stop bit (1), each bit held for OVERSAMPLE clocks.
// A one-entry holding register lets the next character be queued while a
// frame is in flight, so consecutive frames go out with no idle gap.
// Ports:
//   clk16x  : single clock, all state changes on its rising edge
//   reset_n : asynchronous active-low reset
//   bus     : uart_tx_framer_if slave modport (data_in, load, ready, busy,
//             tx, char_complete)
module uart_tx_framer #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic              clk16x,
  input  logic              reset_n,
  uart_tx_framer_if.slave   bus
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_reg_q, shift_reg_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 tx_q, tx_d;
  logic                 char_complete_q, char_complete_d;

  logic                 tick_end;
  logic                 stop_end;
  logic [DATA_BITS-1:0] shifted;

  assign tick_end = (tick_q == LAST_TICK);
  assign stop_end = (state_q == STOP) && tick_end;
  assign shifted  = shift_reg_q >> 1;

  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tick_q          <= '0;
      bit_idx_q       <= '0;
      shift_reg_q     <= '0;
      hold_q          <= '0;
      hold_valid_q    <= 1'b0;
      tx_q            <= 1'b1;
      char_complete_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_idx_q       <= bit_idx_d;
      shift_reg_q     <= shift_reg_d;
      hold_q          <= hold_d;
      hold_valid_q    <= hold_valid_d;
      tx_q            <= tx_d;
      char_complete_q <= char_complete_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    tick_d          = tick_q;
    bit_idx_d       = bit_idx_q;
    shift_reg_d     = shift_reg_q;
    hold_d          = hold_q;
    hold_valid_d    = hold_valid_q;
    tx_d            = tx_q;
    char_complete_d = 1'b0;

    // Queue a character while a frame is in flight. The edge that ends the
    // stop bit is excluded: with the hold empty, a load there starts the
    // next frame directly instead of being parked.
    if (bus.load && (state_q != IDLE) && !hold_valid_q && !stop_end) begin
      hold_d       = bus.data_in;
      hold_valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tick_d    = '0;
        bit_idx_d = '0;
        tx_d      = 1'b1;
        if (bus.load) begin
          shift_reg_d = bus.data_in;
          tx_d        = 1'b0;
          state_d     = START;
        end
      end

      START: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d    = '0;
          bit_idx_d = '0;
          tx_d      = shift_reg_q[0];
          state_d   = DATA;
        end
      end

      DATA: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d      = '0;
          shift_reg_d = shifted;
          if (bit_idx_q == LAST_BIT) begin
            bit_idx_d = '0;
            tx_d      = 1'b1;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            tx_d      = shifted[0];
          end
        end
      end

      STOP: begin
        tick_d = tick_q + 1'b1;
        if (tick_end) begin
          tick_d          = '0;
          char_complete_d = 1'b1;
          // Held data has priority; a load on this edge is ignored then
          // because ready is low.
          if (hold_valid_q) begin
            shift_reg_d  = hold_q;
            hold_valid_d = 1'b0;
            tx_d         = 1'b0;
            state_d      = START;
          end else if (bus.load) begin
            shift_reg_d = bus.data_in;
            tx_d        = 1'b0;
            state_d     = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign bus.tx            = tx_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.ready         = ~hold_valid_q;
  assign bus.char_complete = char_complete_q;

endmodule
